// File: rtl/aurora_hls_axis_gearbox.sv
// aurora_hls_axis_gearbox: single-clock AXI-Stream downsizer with buffer FIFO.
// Wide beats are queued in a DEPTH-entry FIFO, then emitted as RATIO narrow
// lanes (lane 0 = least-significant bytes). On end-of-packet beats, trailing
// lanes with no keep bits set are skipped.
// Optional statistics counters: define AURORA_HLS_GEARBOX_STATS_EN.
module aurora_hls_axis_gearbox #(
  parameter int S_BYTES           = 64,
  parameter int RATIO             = 2,
  parameter int DEPTH             = 32,
  parameter int PROG_FULL_THRESH  = 24,
  parameter int PROG_EMPTY_THRESH = 4
) (
  input  logic                               ap_clk,
  input  logic                               ap_rst_n,
  input  logic [S_BYTES*8-1:0]               s_axis_tdata,
  input  logic [S_BYTES-1:0]                 s_axis_tkeep,
  input  logic                               s_axis_tlast,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic [(S_BYTES/RATIO)*8-1:0]       m_axis_tdata,
  output logic [(S_BYTES/RATIO)-1:0]         m_axis_tkeep,
  output logic                               m_axis_tlast,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
`ifdef AURORA_HLS_GEARBOX_STATS_EN
  input  logic                               stats_clear,
  output logic [31:0]                        pkt_count,
  output logic [31:0]                        byte_count,
`endif
  output logic [$clog2(DEPTH):0]             fifo_level,
  output logic                               prog_full,
  output logic                               prog_empty
);

  localparam int M_BYTES = S_BYTES / RATIO;
  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam int IW      = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int EW      = S_BYTES * 9 + 1;

  typedef enum logic {
    ST_EMPTY,
    ST_SHIFT
  } state_t;

  logic [EW-1:0]        mem [DEPTH];
  logic [EW-1:0]        rd_entry;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 tready_q;
  logic                 push, pop;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        last_lane;
  logic [S_BYTES*8-1:0] beat_data_q;
  logic [S_BYTES-1:0]   beat_keep_q;
  logic                 beat_last_q;
  logic                 m_valid;
  logic                 m_hs;

  assign push     = s_axis_tvalid && tready_q;
  assign rd_entry = mem[rd_ptr_q];
  assign m_valid  = (state_q == ST_SHIFT);
  assign m_hs     = m_valid && m_axis_tready;

  // FIFO storage; pointers and level carry the reset, the array needs none
  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr_q] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // Next-state level: simultaneous push and pop cancel out
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers, level and registered input ready
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q  <= level_d;
      tready_q <= (level_d != LW'(DEPTH));
    end
  end

  // Final lane of the held beat: highest lane with any keep bit on tlast beats
  always_comb begin
    last_lane = IW'(RATIO - 1);
    if (beat_last_q) begin
      last_lane = '0;
      for (int unsigned l = 0; l < RATIO; l++) begin
        if (|beat_keep_q[l*M_BYTES +: M_BYTES]) last_lane = IW'(l);
      end
    end
  end

  // Output-stage FSM: next state, lane index and FIFO pop
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (m_hs) begin
          if (idx_q < last_lane) begin
            idx_d = idx_q + IW'(1);
          end else if (level_q != '0) begin
            // back-to-back reload keeps the link busy without a bubble
            pop   = 1'b1;
            idx_d = '0;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output-stage state, lane index and held beat
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_EMPTY;
      idx_q       <= '0;
      beat_data_q <= '0;
      beat_keep_q <= '0;
      beat_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (pop) {beat_last_q, beat_keep_q, beat_data_q} <= rd_entry;
    end
  end

  assign m_axis_tvalid = m_valid;
  assign m_axis_tdata  = m_valid ? beat_data_q[idx_q*(M_BYTES*8) +: M_BYTES*8] : '0;
  assign m_axis_tkeep  = m_valid ? beat_keep_q[idx_q*M_BYTES +: M_BYTES] : '0;
  assign m_axis_tlast  = m_valid && beat_last_q && (idx_q == last_lane);
  assign s_axis_tready = tready_q;
  assign fifo_level    = level_q;
  assign prog_full     = (level_q >= LW'(PROG_FULL_THRESH));
  assign prog_empty    = (level_q <= LW'(PROG_EMPTY_THRESH));

`ifdef AURORA_HLS_GEARBOX_STATS_EN
  logic [31:0] pkt_count_q, byte_count_q;
  logic [31:0] keep_pop;

  // Number of valid bytes in the current output lane
  always_comb begin
    keep_pop = '0;
    for (int unsigned b = 0; b < M_BYTES; b++) begin
      keep_pop = keep_pop + 32'(m_axis_tkeep[b]);
    end
  end

  // Packet and byte counters; clear takes priority over a same-cycle handshake
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pkt_count_q  <= '0;
      byte_count_q <= '0;
    end else if (stats_clear) begin
      pkt_count_q  <= '0;
      byte_count_q <= '0;
    end else if (m_hs) begin
      pkt_count_q  <= pkt_count_q + 32'(m_axis_tlast);
      byte_count_q <= byte_count_q + keep_pop;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_aurora_hls_axis_gearbox.sv
// Directed self-checking bench for aurora_hls_axis_gearbox (default parameters).
module tb_aurora_hls_axis_gearbox;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [5:0]   fifo_level;
  logic         prog_full;
  logic         prog_empty;
`ifdef AURORA_HLS_GEARBOX_STATS_EN
  logic         stats_clear;
  logic [31:0]  pkt_count;
  logic [31:0]  byte_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  aurora_hls_axis_gearbox #(
    .S_BYTES(64), .RATIO(2), .DEPTH(32), .PROG_FULL_THRESH(24), .PROG_EMPTY_THRESH(4)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
`ifdef AURORA_HLS_GEARBOX_STATS_EN
    .stats_clear   (stats_clear),
    .pkt_count     (pkt_count),
    .byte_count    (byte_count),
`endif
    .fifo_level    (fifo_level),
    .prog_full     (prog_full),
    .prog_empty    (prog_empty)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tready"}, s_axis_tready, 1'b0);
    chk({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
    chk({tag, "_tdata"},  m_axis_tdata, '0);
    chk({tag, "_tkeep"},  m_axis_tkeep, '0);
    chk({tag, "_tlast"},  m_axis_tlast, 1'b0);
    chk({tag, "_level"},  fifo_level, 6'd0);
    chk({tag, "_pfull"},  prog_full, 1'b0);
    chk({tag, "_pempty"}, prog_empty, 1'b1);
  endtask

  initial begin
    logic [7:0] bv;
    int acc;
    ap_rst_n      = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
`ifdef AURORA_HLS_GEARBOX_STATS_EN
    stats_clear   = 1'b0;
`endif

    // Reset values
    #12;
    chk_reset_outputs("rst");
    step();
    ap_rst_n = 1'b1;
    chk("rst_hold_tready", s_axis_tready, 1'b0);
    step();
    chk("rst_rel_tready", s_axis_tready, 1'b1);

    // Packet trimming: upper lane has no keep bits, only lane 0 is sent
    m_axis_tready = 1'b1;
    s_axis_tdata  = {{32{8'h5A}}, {32{8'hA5}}};
    s_axis_tkeep  = 64'h0000_0000_FFFF_FFFF;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    chk("trim_level1", fifo_level, 6'd1);
    chk("trim_novalid", m_axis_tvalid, 1'b0);
    step();
    chk("trim_valid", m_axis_tvalid, 1'b1);
    chk("trim_tdata", m_axis_tdata, {32{8'hA5}});
    chk("trim_tkeep", m_axis_tkeep, 32'hFFFF_FFFF);
    chk("trim_tlast", m_axis_tlast, 1'b1);
    chk("trim_level0", fifo_level, 6'd0);
    step();
    chk("trim_done", m_axis_tvalid, 1'b0);

    // Full-rate streaming: 4 beats -> 8 contiguous lanes, tlast on the 8th
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin
        bv = 8'(8'h10 + 2 * c);
        s_axis_tdata  = {{32{bv + 8'h01}}, {32{bv}}};
        s_axis_tkeep  = '1;
        s_axis_tlast  = (c == 3);
        s_axis_tvalid = 1'b1;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      step();
      if (c >= 1 && c <= 8) begin
        bv = 8'(8'h10 + (c - 1));
        chk("stream_valid", m_axis_tvalid, 1'b1);
        chk("stream_tdata", m_axis_tdata, {32{bv}});
        chk("stream_tlast", m_axis_tlast, (c == 8));
      end else begin
        chk("stream_idle", m_axis_tvalid, 1'b0);
      end
    end

    // Zero-keep end beat still delivers tlast
    s_axis_tdata  = {64{8'h3C}};
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    step();
    chk("zk_valid", m_axis_tvalid, 1'b1);
    chk("zk_tkeep", m_axis_tkeep, 32'h0);
    chk("zk_tlast", m_axis_tlast, 1'b1);
    step();
    chk("zk_done", m_axis_tvalid, 1'b0);

    // Backpressure: 32 in the FIFO plus one held in the output stage
    m_axis_tready = 1'b0;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      bv = 8'(i + 1);
      s_axis_tdata  = {64{bv}};
      s_axis_tkeep  = '1;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      if (s_axis_tready) acc++;
      step();
      if (i == 10 || i == 39) begin
        chk("stall_tdata", m_axis_tdata, {32{8'h01}});
        chk("stall_valid", m_axis_tvalid, 1'b1);
      end
    end
    s_axis_tvalid = 1'b0;
    chk("full_accepted", acc, 33);
    chk("full_level", fifo_level, 6'd32);
    chk("full_tready", s_axis_tready, 1'b0);
    chk("full_pfull", prog_full, 1'b1);
    chk("full_pempty", prog_empty, 1'b0);

    // Drain and watch the threshold flags
    m_axis_tready = 1'b1;
    for (int n = 0; n < 200 && fifo_level != 6'd24; n++) step();
    chk("thr24_level", fifo_level, 6'd24);
    chk("thr24_pfull", prog_full, 1'b1);
    chk("thr24_tdata", m_axis_tdata, {32{8'h09}});
    for (int n = 0; n < 200 && fifo_level != 6'd23; n++) step();
    chk("thr23_level", fifo_level, 6'd23);
    chk("thr23_pfull", prog_full, 1'b0);
    chk("thr23_tdata", m_axis_tdata, {32{8'h0A}});
    for (int n = 0; n < 200 && fifo_level != 6'd5; n++) step();
    chk("thr5_level", fifo_level, 6'd5);
    chk("thr5_pempty", prog_empty, 1'b0);
    for (int n = 0; n < 200 && fifo_level != 6'd4; n++) step();
    chk("thr4_level", fifo_level, 6'd4);
    chk("thr4_pempty", prog_empty, 1'b1);
    chk("thr4_tdata", m_axis_tdata, {32{8'h1D}});
    for (int n = 0; n < 200 && m_axis_tvalid; n++) step();
    chk("drain_valid", m_axis_tvalid, 1'b0);
    chk("drain_level", fifo_level, 6'd0);

    // Mid-packet asynchronous reset
    m_axis_tready = 1'b0;
    s_axis_tdata  = {64{8'h77}};
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    step();
    s_axis_tdata  = {64{8'h88}};
    s_axis_tlast  = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    chk("mid_valid", m_axis_tvalid, 1'b1);
    chk("mid_level", fifo_level, 6'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    ap_rst_n = 1'b1;
    step();
    chk("midrst_tready", s_axis_tready, 1'b1);
    chk("midrst_novalid", m_axis_tvalid, 1'b0);
    chk("midrst_level", fifo_level, 6'd0);

`ifdef AURORA_HLS_GEARBOX_STATS_EN
    chk("stats_rst_pkt", pkt_count, 32'd0);
    chk("stats_rst_byte", byte_count, 32'd0);
    m_axis_tready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      s_axis_tdata  = {64{8'h42}};
      s_axis_tkeep  = 64'h0000_0000_FFFF_FFFF;
      s_axis_tlast  = 1'b1;
      s_axis_tvalid = 1'b1;
      step();
      s_axis_tvalid = 1'b0;
      step();
      step();
    end
    chk("stats_pkt", pkt_count, 32'd2);
    chk("stats_byte", byte_count, 32'd64);
    stats_clear = 1'b1;
    step();
    stats_clear = 1'b0;
    chk("stats_clr_pkt", pkt_count, 32'd0);
    chk("stats_clr_byte", byte_count, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
